// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, stop bit(s),
// with an internal bit timer. Define UART_TX_STOP2_EN to send two stop bits per frame.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESC_W-1:0]    Prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_STOP2_EN
    , S_STOP2
`endif
  } state_e;

  state_e                  state_q;
  logic [PRESC_W-1:0]      edge_cnt_q;
  logic [BIT_W-1:0]        bit_cnt_q;
  logic                    tx_q;
  logic                    busy_q;

  logic [DATA_WIDTH-1:0]   shift_q;
  logic [DATA_WIDTH-1:0]   shift_d;
  logic [PRESC_W-1:0]      presc_q;
  logic                    par_en_q;
  logic                    par_bit_q;

  logic [PRESC_W-1:0]      presc_eff;
  logic                    bit_end;
  logic                    last_stop;
  logic                    accept;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic odd);
    parity_bit = (^data) ^ odd;
  endfunction

  always_comb begin
    presc_eff = (Prescale == '0) ? PRESC_W'(1) : Prescale;
    bit_end   = (edge_cnt_q == (presc_q - PRESC_W'(1)));
    shift_d   = shift_q >> 1;
`ifdef UART_TX_STOP2_EN
    last_stop = (state_q == S_STOP2);
`else
    last_stop = (state_q == S_STOP);
`endif
    // A frame can start from idle or be chained onto the final stop-bit cycle.
    accept    = DATA_VALID && ((state_q == S_IDLE) || (last_stop && bit_end));
  end

  // Control FSM: state, bit timer, bit counter and the registered line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else if (accept) begin
      state_q    <= S_START;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b0;
      busy_q     <= 1'b1;
    end else if (state_q == S_IDLE) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else if (!bit_end) begin
      edge_cnt_q <= edge_cnt_q + PRESC_W'(1);
    end else begin
      edge_cnt_q <= '0;
      case (state_q)
        S_START: begin
          state_q <= S_DATA;
          tx_q    <= shift_q[0];
        end
        S_DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_q <= '0;
            if (par_en_q) begin
              state_q <= S_PARITY;
              tx_q    <= par_bit_q;
            end else begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            tx_q      <= shift_d[0];
          end
        end
        S_PARITY: begin
          state_q <= S_STOP;
          tx_q    <= 1'b1;
        end
`ifdef UART_TX_STOP2_EN
        S_STOP: begin
          state_q <= S_STOP2;
          tx_q    <= 1'b1;
        end
`endif
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Frame shadow registers: captured on accept so input changes mid-frame are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_q   <= P_DATA;
      presc_q   <= presc_eff;
      par_en_q  <= PAR_EN;
      par_bit_q <= parity_bit(P_DATA, PAR_TYP);
    end else if ((state_q == S_DATA) && bit_end) begin
      shift_q   <= shift_d;
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed and random frames compared cycle-by-cycle against a
// frame-level model built from the serial format rules.
module tb_uart_tx;

  localparam int DW = 8;
  localparam int PW = 5;
`ifdef UART_TX_STOP2_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          dv;
  logic          pe;
  logic          pt;
  logic [PW-1:0] ps;
  logic          tx;
  logic          busy;

  int   passed = 0;
  int   total  = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .P_DATA    (p_data),
    .DATA_VALID(dv),
    .PAR_EN    (pe),
    .PAR_TYP   (pt),
    .Prescale  (ps),
    .TX_OUT    (tx),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
  endtask

  // Expected line level for every cycle of one frame.
  task automatic add_frame(input logic [DW-1:0] d, input logic e, input logic t, input int p);
    logic bits[$];
    int   pl;
    pl = (p == 0) ? 1 : p;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (e) bits.push_back((^d) ^ t);
    for (int i = 0; i < NSTOP; i++) bits.push_back(1'b1);
    foreach (bits[i])
      for (int j = 0; j < pl; j++) exp_q.push_back(bits[i]);
  endtask

  task automatic launch(input logic [DW-1:0] d, input logic e, input logic t, input logic [PW-1:0] p);
    p_data = d; pe = e; pt = t; ps = p; dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    add_frame(d, e, t, int'(p));
  endtask

  task automatic check_stream(input string tag, input int dv_from, input int dv_to,
                              input logic [DW-1:0] nd, input logic ne, input logic nt,
                              input logic [PW-1:0] np);
    int k;
    k = 0;
    while (exp_q.size() > 0) begin
      if (k >= dv_from && k <= dv_to) begin
        dv = 1'b1; p_data = nd; pe = ne; pt = nt; ps = np;
      end else begin
        dv = 1'b0; p_data = DW'($urandom); pe = 1'($urandom);
        pt = 1'($urandom); ps = PW'($urandom);
      end
      chk({tag, "_tx"}, tx, exp_q.pop_front());
      chk({tag, "_busy"}, busy, 1'b1);
      k++;
      @(negedge clk);
    end
    dv = 1'b0;
    chk({tag, "_idle_tx"}, tx, 1'b1);
    chk({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; dv = 1'b0; p_data = '0; pe = 1'b0; pt = 1'b0; ps = PW'(8);
    @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_tx", tx, 1'b1);
    chk("idle_busy", busy, 1'b0);

    launch(8'hA5, 1'b0, 1'b0, PW'(8));
    check_stream("a5_nopar", -1, -1, '0, 1'b0, 1'b0, '0);
    launch(8'hA5, 1'b1, 1'b0, PW'(8));
    check_stream("a5_even", -1, -1, '0, 1'b0, 1'b0, '0);
    launch(8'hA5, 1'b1, 1'b1, PW'(8));
    check_stream("a5_odd", -1, -1, '0, 1'b0, 1'b0, '0);
    launch(8'h07, 1'b1, 1'b0, PW'(4));
    check_stream("07_even", -1, -1, '0, 1'b0, 1'b0, '0);

    // Back-to-back: DATA_VALID held high through the first frame carrying the second.
    launch(8'h55, 1'b0, 1'b0, PW'(4));
    add_frame(8'hAA, 1'b0, 1'b0, 4);
    check_stream("b2b", 0, 4 * (1 + DW + NSTOP) - 1, 8'hAA, 1'b0, 1'b0, PW'(4));

    // Request during data bits is dropped.
    launch(8'h00, 1'b0, 1'b0, PW'(4));
    check_stream("ignore", 12, 12, 8'hFF, 1'b0, 1'b0, PW'(4));
    repeat (3) begin
      @(negedge clk);
      chk("ignore_after_tx", tx, 1'b1);
      chk("ignore_after_busy", busy, 1'b0);
    end

    // Asynchronous reset in the middle of the data bits.
    launch(8'h3C, 1'b0, 1'b0, PW'(8));
    exp_q.delete();
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(8'h3C, 1'b1, 1'b1, PW'(8));
    check_stream("after_rst", -1, -1, '0, 1'b0, 1'b0, '0);

    launch(8'h96, 1'b1, 1'b1, PW'(0));
    check_stream("presc0", -1, -1, '0, 1'b0, 1'b0, '0);

    for (int n = 0; n < 8; n++) begin
      launch(DW'($urandom), 1'($urandom), 1'($urandom), PW'($urandom_range(0, 6)));
      check_stream("rand", -1, -1, '0, 1'b0, 1'b0, '0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
